instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter ADDR_W, default 32: width of the instruction-memory byte address output.
REQ-002 Parameter BASE_ADDR, default 0: first word address issued after reset.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  request word present on the in_* fields.
REQ-006 in_ready  output  1  encoder accepts a request this cycle.
REQ-007 in_fmt  input  2  format select: 00 I, 01 S, 10 B, 11 J (same encoding as the decode-side ImmSrc).
REQ-008 in_opcode  input  7  opcode, bits [6:0] of the output word.
REQ-009 in_rd, in_rs1, in_rs2  input  5 each  register indices.
REQ-010 in_funct3  input  3  funct3 field.
REQ-011 in_imm  input  32  signed two's-complement immediate (byte offset for B and J).
REQ-012 out_valid  output  1  encoded word present.
REQ-013 out_ready  input  1  consumer accepts the word.
REQ-014 out_instr  output  32  encoded instruction word.
REQ-015 out_addr  output  ADDR_W  byte address of out_instr.
REQ-016 out_err  output  1  immediate not representable; out_instr carries NOP.
REQ-017 err_count  output  8  count of errored words delivered, saturating.

Function
REQ-018 The block SHALL be a 2-stage valid/ready pipeline: S1 registers the request and the range check; S2 holds the packed word, address and error flag.
REQ-019 Latency from the in_valid&&in_ready cycle to out_valid SHALL be 2 cycles when out_ready is held high.
REQ-020 A stage SHALL load when it is empty or when its contents advance in the same cycle; in_ready = !S1_valid || S1 advances.
REQ-021 Sustained throughput with out_ready=1 SHALL be one word per cycle; no request is dropped or duplicated under any out_ready pattern.
REQ-022 Encoding: I {imm[11:0],rs1,f3,rd,op}; S {imm[11:5],rs2,rs1,f3,imm[4:0],op}; B {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}; J {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}.
REQ-023 Legal ranges: I/S imm[31:11] all equal; B imm[31:12] all equal and imm[0]=0; J imm[31:20] all equal and imm[0]=0.
REQ-024 For an illegal immediate, the block SHALL set out_instr=32'h00000013 and out_err=1; the word SHALL still occupy an address.
REQ-025 out_addr SHALL start at BASE_ADDR and advance by 4 on each out_valid&&out_ready, wrapping modulo 2^ADDR_W.
REQ-026 err_count SHALL increment on each out_valid&&out_ready&&out_err, holding at 255.
REQ-027 While out_valid=1 and out_ready=0, out_instr, out_addr and out_err SHALL remain stable.
REQ-028 Unused fields (rs2 in I/J, rd in S/B, etc.) SHALL NOT affect out_instr.

Reset
REQ-029 While rst=1: S1_valid=0, out_valid=0, out_err=0, out_instr=0, out_addr=BASE_ADDR, err_count=0, in_ready=0.
REQ-030 rst mid-transfer SHALL discard all in-flight words; in_ready SHALL rise in the first cycle after rst deasserts.

Structure
REQ-031 A shared package SHALL hold the format codes (FMT_I/S/B/J), the NOP constant 32'h00000013, and the opcode constants OP_IMM, OP_STORE, OP_BRANCH and OP_JAL.
REQ-032 The range check SHALL be a sub-module imm_range_check (inputs fmt and imm; output legal), kept purely combinational.

Verification
REQ-033 I: op=0010011, rd=1, rs1=0, f3=0, imm=5 -> out_instr 0x00500093, addr 0x0, err 0.
REQ-034 S: op=0100011, rs2=2, rs1=0, f3=010, imm=8 -> 0x00202423; B: op=1100011, imm=-4 -> 0xFE000EE3.
REQ-035 J: op=1101111, rd=1, imm=2048 -> 0x001000EF.
REQ-036 Errors: I imm=2048 -> 0x00000013 with err=1; B imm=3 -> err=1; err_count reads 2 and out_addr still advances by 4 per word.
REQ-037 Backpressure: stream 4 words, hold out_ready=0 for 3 cycles -> in_ready=0 once 2 words are buffered; all 4 words emerge in order at addresses 0, 4, 8, 12.
REQ-038 Reset: assert rst with 2 words in flight -> out_valid=0 the next cycle; the first word after reset lands at BASE_ADDR.

Source files
------------

// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the instruction encoder: format codes, opcodes,
// the NOP word and the field-packing helper used by the output stage.
package instr_encoder_pkg;

    typedef enum logic [1:0] {
        FMT_I = 2'b00,
        FMT_S = 2'b01,
        FMT_B = 2'b10,
        FMT_J = 2'b11
    } fmt_e;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // A request as captured by the first pipeline stage, including the
    // result of the immediate range check.
    typedef struct packed {
        fmt_e        fmt;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [31:0] imm;
        logic        legal;
    } req_t;

    // Scatter the fields into the 32-bit word; fields a format does not use
    // are simply not referenced, so they cannot leak into the result.
    function automatic logic [31:0] packInstr(input req_t r);
        logic [31:0] word;
        word = '0;
        case (r.fmt)
            FMT_I: word = {r.imm[11:0], r.rs1, r.funct3, r.rd, r.opcode};
            FMT_S: word = {r.imm[11:5], r.rs2, r.rs1, r.funct3, r.imm[4:0], r.opcode};
            FMT_B: word = {r.imm[12], r.imm[10:5], r.rs2, r.rs1, r.funct3,
                           r.imm[4:1], r.imm[11], r.opcode};
            FMT_J: word = {r.imm[20], r.imm[10:1], r.imm[11], r.imm[19:12],
                           r.rd, r.opcode};
            default: word = NOP_INSTR;
        endcase
        return word;
    endfunction

endpackage

// File: rtl/instr_encoder_imm_range_check.sv
// Purely combinational check that an immediate fits the selected format:
// the upper bits must be a sign extension and B/J offsets must be even.
module imm_range_check
    import instr_encoder_pkg::*;
(
    input  logic [1:0]  fmt,
    input  logic [31:0] imm,
    output logic        legal
);

    // Sign-extension test over the bits above each format's field width.
    always_comb begin
        legal = 1'b0;
        case (fmt)
            FMT_I, FMT_S: legal = (&imm[31:11]) || !(|imm[31:11]);
            FMT_B:        legal = ((&imm[31:12]) || !(|imm[31:12])) && !imm[0];
            FMT_J:        legal = ((&imm[31:20]) || !(|imm[31:20])) && !imm[0];
            default:      legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Two-stage valid/ready instruction encoder. Stage 1 captures the request
// together with its range check; stage 2 holds the packed word, its byte
// address and the error flag until the consumer takes it.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_fmt,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err,
    output logic [7:0]        err_count
);

    logic              s1Valid_q, s1Valid_d;
    req_t              s1Req_q, s1Req_d;
    logic              outValid_q, outValid_d;
    logic [31:0]       outInstr_q, outInstr_d;
    logic              outErr_q, outErr_d;
    logic [ADDR_W-1:0] outAddr_q, outAddr_d;
    logic [7:0]        errCount_q, errCount_d;

    logic inLegal;
    logic s2Fire;
    logic s1Advance;
    logic s1Load;

    imm_range_check u_range (
        .fmt   (in_fmt),
        .imm   (in_imm),
        .legal (inLegal)
    );

    // Handshakes: stage 2 drains on out_ready, stage 1 moves whenever stage 2
    // is empty or draining, and a new request lands whenever stage 1 is free
    // or moving. in_ready is held low for the whole reset cycle.
    assign s2Fire    = outValid_q && out_ready;
    assign s1Advance = s1Valid_q && (!outValid_q || out_ready);
    assign in_ready  = !rst && (!s1Valid_q || s1Advance);
    assign s1Load    = in_valid && in_ready;

    // Next-state for both stages, the address counter and the error counter.
    always_comb begin
        s1Valid_d  = s1Valid_q;
        s1Req_d    = s1Req_q;
        outValid_d = outValid_q;
        outInstr_d = outInstr_q;
        outErr_d   = outErr_q;
        outAddr_d  = outAddr_q;
        errCount_d = errCount_q;

        if (s1Load) begin
            s1Valid_d      = 1'b1;
            s1Req_d.fmt    = fmt_e'(in_fmt);
            s1Req_d.opcode = in_opcode;
            s1Req_d.rd     = in_rd;
            s1Req_d.rs1    = in_rs1;
            s1Req_d.rs2    = in_rs2;
            s1Req_d.funct3 = in_funct3;
            s1Req_d.imm    = in_imm;
            s1Req_d.legal  = inLegal;
        end else if (s1Advance) begin
            s1Valid_d = 1'b0;
        end

        if (s1Advance) begin
            outValid_d = 1'b1;
            outInstr_d = s1Req_q.legal ? packInstr(s1Req_q) : NOP_INSTR;
            outErr_d   = !s1Req_q.legal;
        end else if (s2Fire) begin
            outValid_d = 1'b0;
        end

        if (s2Fire) begin
            outAddr_d = outAddr_q + ADDR_W'(4);
            if (outErr_q && (errCount_q != 8'hFF)) begin
                errCount_d = errCount_q + 8'd1;
            end
        end
    end

    // State registers with synchronous reset that drops any in-flight words.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1Valid_q  <= 1'b0;
            s1Req_q    <= '0;
            outValid_q <= 1'b0;
            outInstr_q <= '0;
            outErr_q   <= 1'b0;
            outAddr_q  <= BASE_ADDR;
            errCount_q <= '0;
        end else begin
            s1Valid_q  <= s1Valid_d;
            s1Req_q    <= s1Req_d;
            outValid_q <= outValid_d;
            outInstr_q <= outInstr_d;
            outErr_q   <= outErr_d;
            outAddr_q  <= outAddr_d;
            errCount_q <= errCount_d;
        end
    end

    assign out_valid = outValid_q;
    assign out_instr = outInstr_q;
    assign out_err   = outErr_q;
    assign out_addr  = outAddr_q;
    assign err_count = errCount_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: a table of hand-encoded requests pushed
// through the pipeline, a scoreboard monitor on the output side, and short
// hand-written sequences for latency, backpressure, reset and saturation.
module tb_instr_encoder;
    import instr_encoder_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_fmt;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [2:0]  in_funct3;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        out_err;
    logic [7:0]  err_count;

    typedef struct {
        logic [1:0]  fmt;
        logic [6:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [31:0] imm;
        logic [31:0] expInstr;
        logic        expErr;
    } vec_t;

    typedef struct packed {
        logic [31:0] instr;
        logic        err;
    } exp_t;

    vec_t vecs[14];
    exp_t expQ[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int startCyc;
    bit doneB;

    logic [31:0] expAddr = 32'h0;
    logic [7:0]  expErrCnt = 8'h0;
    logic        rstAtEdge = 1'b0;
    logic        snapValid = 1'b0;
    logic [31:0] snapInstr, snapAddr;
    logic        snapErr;

    localparam logic [31:0] BASE = 32'h0;

    instr_encoder #(.ADDR_W(32), .BASE_ADDR(BASE)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_fmt    (in_fmt),
        .in_opcode (in_opcode),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_funct3 (in_funct3),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_addr  (out_addr),
        .out_err   (out_err),
        .err_count (err_count)
    );

    // Free-running clock and cycle counter.
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        rstAtEdge <= rst;
    end

    // Hard stop in case something wedges outside the bounded waits.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mkVec(input logic [1:0] fmt, input logic [6:0] op,
                                   input logic [4:0] rd, input logic [4:0] rs1,
                                   input logic [4:0] rs2, input logic [2:0] f3,
                                   input logic [31:0] imm, input logic [31:0] expInstr,
                                   input logic expErr);
        vec_t v;
        v.fmt = fmt; v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
        v.f3 = f3; v.imm = imm; v.expInstr = expInstr; v.expErr = expErr;
        return v;
    endfunction

    // Present one request and hold it until accepted; the expected result is
    // queued at the handshake so the monitor sees words in acceptance order.
    task automatic applyStimulus(input vec_t v);
        bit accepted;
        exp_t e;
        accepted  = 1'b0;
        in_valid  = 1'b1;
        in_fmt    = v.fmt;
        in_opcode = v.op;
        in_rd     = v.rd;
        in_rs1    = v.rs1;
        in_rs2    = v.rs2;
        in_funct3 = v.f3;
        in_imm    = v.imm;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                e.instr = v.expInstr;
                e.err   = v.expErr;
                expQ.push_back(e);
                accepted = 1'b1;
                break;
            end
        end
        if (!accepted) begin
            total++;
            bad++;
            $display("[TB] FAIL acceptTimeout: got in_ready=0 expected in_ready=1 within 100 cycles");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Wait until every queued word has left the pipeline.
    task automatic waitDrain(input string name);
        bit drained;
        drained = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (expQ.size() == 0 && !out_valid) begin
                drained = 1'b1;
                break;
            end
        end
        checkOutput(name, 32'(drained), 32'd1);
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Output-side scoreboard: reset values, order, address, error flag,
    // error counter and stability of a stalled word.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            checkOutput("inReadyInReset", 32'(in_ready), 32'd0);
            if (rstAtEdge) begin
                checkOutput("rstOutValid", 32'(out_valid), 32'd0);
                checkOutput("rstOutErr", 32'(out_err), 32'd0);
                checkOutput("rstOutInstr", out_instr, 32'h0);
                checkOutput("rstOutAddr", out_addr, BASE);
                checkOutput("rstErrCount", 32'(err_count), 32'd0);
            end
            expQ.delete();
            expAddr = BASE;
            expErrCnt = 8'h0;
            snapValid = 1'b0;
        end else begin
            checkOutput("errCount", 32'(err_count), 32'(expErrCnt));
            if (snapValid) begin
                checkOutput("stallValid", 32'(out_valid), 32'd1);
                checkOutput("stallInstr", out_instr, snapInstr);
                checkOutput("stallAddr", out_addr, snapAddr);
                checkOutput("stallErr", 32'(out_err), 32'(snapErr));
            end
            if (out_valid && out_ready) begin
                if (expQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL spuriousWord: got instr 0x%08h expected no word", out_instr);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("instr", out_instr, e.instr);
                    checkOutput("err", 32'(out_err), 32'(e.err));
                    checkOutput("addr", out_addr, expAddr);
                    if (e.err && expErrCnt != 8'hFF) expErrCnt = expErrCnt + 8'd1;
                end
                expAddr = expAddr + 32'd4;
            end
            snapValid = out_valid && !out_ready;
            snapInstr = out_instr;
            snapAddr  = out_addr;
            snapErr   = out_err;
        end
    end

    // Directed test sequence.
    initial begin
        vecs[0]  = mkVec(FMT_I, 7'h13, 5'd1,  5'd0,  5'd0,  3'd0, 32'd5,        32'h00500093, 1'b0);
        vecs[1]  = mkVec(FMT_S, 7'h23, 5'd0,  5'd0,  5'd2,  3'd2, 32'd8,        32'h00202423, 1'b0);
        vecs[2]  = mkVec(FMT_B, 7'h63, 5'd0,  5'd0,  5'd0,  3'd0, 32'hFFFFFFFC, 32'hFE000EE3, 1'b0);
        vecs[3]  = mkVec(FMT_J, 7'h6F, 5'd1,  5'd0,  5'd0,  3'd0, 32'd2048,     32'h001000EF, 1'b0);
        vecs[4]  = mkVec(FMT_I, 7'h13, 5'd1,  5'd0,  5'd0,  3'd0, 32'd2048,     32'h00000013, 1'b1);
        vecs[5]  = mkVec(FMT_B, 7'h63, 5'd0,  5'd0,  5'd0,  3'd0, 32'd3,        32'h00000013, 1'b1);
        vecs[6]  = mkVec(FMT_I, 7'h13, 5'd5,  5'd6,  5'd31, 3'd7, 32'hFFFFFFFF, 32'hFFF37293, 1'b0);
        vecs[7]  = mkVec(FMT_S, 7'h23, 5'd31, 5'd4,  5'd3,  3'd1, 32'hFFFFF800, 32'h80321023, 1'b0);
        vecs[8]  = mkVec(FMT_B, 7'h63, 5'd31, 5'd2,  5'd1,  3'd1, 32'h00000FFE, 32'h7E111FE3, 1'b0);
        vecs[9]  = mkVec(FMT_J, 7'h6F, 5'd2,  5'd31, 5'd31, 3'd7, 32'hFFFFFFFE, 32'hFFFFF16F, 1'b0);
        vecs[10] = mkVec(FMT_J, 7'h6F, 5'd1,  5'd0,  5'd0,  3'd0, 32'h00100000, 32'h00000013, 1'b1);
        vecs[11] = mkVec(FMT_S, 7'h23, 5'd0,  5'd0,  5'd0,  3'd0, 32'hFFFFF7FF, 32'h00000013, 1'b1);
        vecs[12] = mkVec(FMT_B, 7'h63, 5'd0,  5'd0,  5'd0,  3'd0, 32'h00001000, 32'h00000013, 1'b1);
        vecs[13] = mkVec(FMT_I, 7'h13, 5'd0,  5'd0,  5'd0,  3'd0, 32'h000007FF, 32'h7FF00013, 1'b0);

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_fmt = '0; in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        in_funct3 = '0; in_imm = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("inReadyAfterReset", 32'(in_ready), 32'd1);

        // Two-cycle latency, then back-to-back throughput for the rest.
        @(posedge clk); #1;
        applyStimulus(vecs[0]);
        @(negedge clk);
        checkOutput("latencyStage1", 32'(out_valid), 32'd0);
        @(negedge clk);
        checkOutput("latencyStage2", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
        startCyc = cyc;
        for (int i = 1; i < 6; i++) applyStimulus(vecs[i]);
        checkOutput("throughput", 32'(cyc - startCyc), 32'd5);
        waitDrain("drainA");
        checkOutput("errCountA", 32'(err_count), 32'd2);
        checkOutput("addrA", out_addr, 32'd24);

        // Remaining vectors under random consumer backpressure.
        @(posedge clk); #1;
        doneB = 1'b0;
        fork
            begin
                for (int i = 6; i < 14; i++) applyStimulus(vecs[i]);
                doneB = 1'b1;
            end
            begin
                while (!doneB) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        waitDrain("drainB");
        checkOutput("errCountB", 32'(err_count), 32'd5);
        checkOutput("addrB", out_addr, 32'd56);

        // Burst of four with the consumer stalled.
        doReset();
        out_ready = 1'b0;
        applyStimulus(vecs[0]);
        applyStimulus(vecs[1]);
        @(negedge clk);
        checkOutput("inReadyFull", 32'(in_ready), 32'd0);
        fork
            begin
                applyStimulus(vecs[2]);
                applyStimulus(vecs[3]);
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        waitDrain("drainBurst");
        checkOutput("addrBurst", out_addr, 32'd16);

        // Reset with two words in flight.
        @(posedge clk); #1;
        out_ready = 1'b0;
        applyStimulus(vecs[4]);
        applyStimulus(vecs[6]);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("flushOutValid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("inReadyRelease", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        applyStimulus(vecs[3]);
        waitDrain("drainFlush");
        checkOutput("addrAfterFlush", out_addr, BASE + 32'd4);
        checkOutput("errAfterFlush", 32'(err_count), 32'd0);

        // Error counter saturation.
        doReset();
        out_ready = 1'b1;
        for (int i = 0; i < 260; i++) applyStimulus(vecs[4]);
        waitDrain("drainSat");
        checkOutput("errCountSat", 32'(err_count), 32'd255);
        checkOutput("addrSat", out_addr, 32'd1040);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
